// File: rtl/alu_pkg.sv
// Shared ALU definitions: add/sub opcode encoding and decode helpers.
package alu_pkg;

  typedef enum logic [1:0] {
    ADD     = 2'b00,
    SUB     = 2'b01,
    ADD_SAT = 2'b10,
    SUB_SAT = 2'b11
  } addsub_op_e;

  function automatic logic is_sub(addsub_op_e op);
    return op[0];
  endfunction

  function automatic logic is_sat(addsub_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/adder_segment.sv
// One combinational slice of the segmented carry chain.
module adder_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  logic [SEG:0] s;

  assign s    = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
  assign sum  = s[SEG-1:0];
  assign cout = s[SEG];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined add/sub with optional signed saturation; one carry-chain segment per stage,
// valid/ready on both sides with bubble-collapsing flow control.
module pipelined_add_sub
  import alu_pkg::*;
#(
  parameter int BUS    = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  addsub_op_e       op,
  input  logic [BUS-1:0]   data_a,
  input  logic [BUS-1:0]   data_b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS-1:0]   data_res,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic [TAG_W-1:0] tag_out
);

  localparam int SEG = BUS / STAGES;

  if (STAGES < 1 || STAGES > BUS || (BUS % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_add_sub: BUS must be a multiple of STAGES (1..BUS)");
  end

  // Element 0 is the issue-side view; element k is stage k's register bank.
  logic [BUS-1:0]   a_s   [STAGES];
  logic [BUS-1:0]   b_s   [STAGES];
  logic [BUS-1:0]   r_s   [STAGES];
  logic             c_s   [STAGES];
  addsub_op_e       op_s  [STAGES];
  logic [TAG_W-1:0] tag_s [STAGES];

  logic [STAGES:1]   vld_pipe, vld_in;
  logic [STAGES+1:1] en;

  assign a_s[0]   = data_a;
  assign b_s[0]   = is_sub(op) ? ~data_b : data_b;
  assign r_s[0]   = '0;
  assign c_s[0]   = is_sub(op);
  assign op_s[0]  = op;
  assign tag_s[0] = tag_in;

  // Ready ripples back from the consumer; an empty stage always accepts.
  always_comb begin
    en            = '0;
    en[STAGES+1]  = out_ready;
    for (int k = STAGES; k >= 1; k--) en[k] = !vld_pipe[k] || en[k+1];
    vld_in        = '0;
    vld_in[1]     = in_valid;
    for (int k = 2; k <= STAGES; k++) vld_in[k] = vld_pipe[k-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++)
        if (en[k]) vld_pipe[k] <= vld_in[k];
    end
  end

  assign in_ready  = en[1];
  assign out_valid = vld_pipe[STAGES];

  for (genvar k = 1; k <= STAGES; k++) begin : g_stg
    logic [SEG-1:0] sum;
    logic           cout;
    logic [BUS-1:0] raw;

    adder_segment #(.SEG(SEG)) u_seg (
      .a    (a_s[k-1][k*SEG-1 -: SEG]),
      .b    (b_s[k-1][k*SEG-1 -: SEG]),
      .cin  (c_s[k-1]),
      .sum  (sum),
      .cout (cout)
    );

    always_comb begin
      raw                  = r_s[k-1];
      raw[k*SEG-1 -: SEG]  = sum;
    end

    if (k < STAGES) begin : g_mid
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          a_s[k]   <= '0;
          b_s[k]   <= '0;
          r_s[k]   <= '0;
          c_s[k]   <= 1'b0;
          op_s[k]  <= ADD;
          tag_s[k] <= '0;
        end else if (en[k]) begin
          a_s[k]   <= a_s[k-1];
          b_s[k]   <= b_s[k-1];
          r_s[k]   <= raw;
          c_s[k]   <= cout;
          op_s[k]  <= op_s[k-1];
          tag_s[k] <= tag_s[k-1];
        end
      end
    end else begin : g_fin
      logic           ovf;
      logic [BUS-1:0] res;

      // Saturate toward the sign of A: same-sign operands overflowed away from it.
      always_comb begin
        ovf = (a_s[k-1][BUS-1] == b_s[k-1][BUS-1]) && (raw[BUS-1] != a_s[k-1][BUS-1]);
        res = raw;
        if (is_sat(op_s[k-1]) && ovf)
          res = a_s[k-1][BUS-1] ? {1'b1, {(BUS-1){1'b0}}} : {1'b0, {(BUS-1){1'b1}}};
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          data_res <= '0;
          carry    <= 1'b0;
          overflow <= 1'b0;
          zero     <= 1'b0;
          tag_out  <= '0;
        end else if (en[k]) begin
          data_res <= res;
          carry    <= cout;
          overflow <= ovf;
          zero     <= (res == '0);
          tag_out  <= tag_s[k-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboard bench for pipelined_add_sub (BUS=32, STAGES=4, TAG_W=5).
module tb_pipelined_add_sub;
  import alu_pkg::*;

  localparam int BUS = 32, STAGES = 4, TAG_W = 5;

  typedef struct packed {
    logic [BUS-1:0]   res;
    logic             c;
    logic             v;
    logic             z;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, carry, overflow, zero;
  addsub_op_e op = ADD;
  logic [BUS-1:0] data_a = '0, data_b = '0, data_res;
  logic [TAG_W-1:0] tag_in = '0, tag_out;

  int total = 0, bad = 0, rx_cnt = 0;
  exp_t sb[$];

  pipelined_add_sub #(.BUS(BUS), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .data_a(data_a), .data_b(data_b), .tag_in(tag_in), .out_valid(out_valid),
    .out_ready(out_ready), .data_res(data_res), .carry(carry), .overflow(overflow),
    .zero(zero), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  localparam addsub_op_e     D_OP  [6] = '{ADD, ADD, ADD_SAT, SUB, SUB_SAT, SUB};
  localparam logic [BUS-1:0] D_A   [6] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'h8000_0000, 32'd9};
  localparam logic [BUS-1:0] D_B   [6] = '{32'd1, 32'd1, 32'd1, 32'd7, 32'd1, 32'd9};
  localparam logic [BUS-1:0] D_RES [6] = '{32'h0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0000, 32'h0};
  localparam logic [2:0]     D_CVZ [6] = '{3'b101, 3'b010, 3'b010, 3'b000, 3'b110, 3'b101};

  function automatic exp_t model(addsub_op_e o, logic [BUS-1:0] a, logic [BUS-1:0] b, logic [TAG_W-1:0] t);
    logic [BUS-1:0] bp, raw;
    logic [BUS:0]   full;
    logic           sub, sat;
    exp_t e;
    sub   = (o == SUB) || (o == SUB_SAT);
    sat   = (o == ADD_SAT) || (o == SUB_SAT);
    bp    = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, bp} + {{BUS{1'b0}}, sub};
    raw   = full[BUS-1:0];
    e.c   = full[BUS];
    e.v   = (a[BUS-1] == bp[BUS-1]) && (raw[BUS-1] != a[BUS-1]);
    e.res = (sat && e.v) ? (a[BUS-1] ? 32'h8000_0000 : 32'h7FFF_FFFF) : raw;
    e.z   = (e.res == '0);
    e.tag = t;
    return e;
  endfunction

  // Scoreboard monitor plus output-hold check while stalled.
  exp_t held;
  logic hold_prev = 1'b0;
  always @(negedge clk) begin
    exp_t obs, e;
    obs = {data_res, carry, overflow, zero, tag_out};
    if (!reset_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && out_valid) begin
        total++;
        if (obs !== held) begin
          bad++;
          $display("FAIL hold_stable got=%h required=%h", obs, held);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_result tag=%0d res=%h, required no output", tag_out, data_res);
        end else begin
          e = sb.pop_front();
          rx_cnt++;
          if (obs !== e) begin
            bad++;
            $display("FAIL result got res=%h c=%b v=%b z=%b tag=%0d, required res=%h c=%b v=%b z=%b tag=%0d",
                     obs.res, obs.c, obs.v, obs.z, obs.tag, e.res, e.c, e.v, e.z, e.tag);
          end
        end
      end
      hold_prev = out_valid && !out_ready;
      held      = obs;
    end
  end

  task automatic issue(input addsub_op_e o, input logic [BUS-1:0] a, input logic [BUS-1:0] b,
                       input logic [TAG_W-1:0] t);
    logic rdy;
    int   n;
    op = o; data_a = a; data_b = b; tag_in = t; in_valid = 1'b1;
    rdy = 1'b0; n = 0;
    while (!rdy && n < 100) begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); n++;
    end
    if (!rdy) begin
      total++; bad++;
      $display("FAIL issue_timeout tag=%0d in_ready=0, required 1", t);
    end else begin
      sb.push_back(model(o, a, b, t));
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 1;
    @(negedge clk);
    while (!out_valid && cyc < 20) begin
      @(negedge clk); cyc++;
    end
  endtask

  task automatic drain(input int want);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk); n++;
    end
    total++;
    if (sb.size() != 0 || rx_cnt != want) begin
      bad++;
      $display("FAIL drain pending=%0d received=%0d, required pending=0 received=%0d", sb.size(), rx_cnt, want);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_hs out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    total++;
    if (data_res !== '0 || tag_out !== '0) begin
      bad++; $display("FAIL reset_data res=%h tag=%0d, required 0 0", data_res, tag_out);
    end
    total++;
    if ({carry, overflow, zero} !== 3'b000) begin
      bad++; $display("FAIL reset_flags cvz=%b, required 000", {carry, overflow, zero});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    int cyc;
    for (int i = 0; i < 6; i++) begin
      issue(D_OP[i], D_A[i], D_B[i], TAG_W'(i + 3));
      wait_out(cyc);
      total++;
      if (cyc != STAGES) begin
        bad++; $display("FAIL latency_%0d got=%0d required=%0d", i, cyc, STAGES);
      end
      total++;
      if (data_res !== D_RES[i] || {carry, overflow, zero} !== D_CVZ[i] || tag_out !== TAG_W'(i + 3)) begin
        bad++;
        $display("FAIL directed_%0d got res=%h cvz=%b tag=%0d, required res=%h cvz=%b tag=%0d",
                 i, data_res, {carry, overflow, zero}, tag_out, D_RES[i], D_CVZ[i], i + 3);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    int base = rx_cnt;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++)
          issue(addsub_op_e'(2'($urandom_range(0, 3))), $urandom, $urandom, TAG_W'(i));
      end
      begin
        for (int c = 0; c < 16; c++) begin
          @(posedge clk); #2;
          out_ready = !(c >= 6 && c <= 8);
          @(negedge clk);
          if (!out_ready) begin
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
              bad++;
              $display("FAIL stall_full cyc=%0d in_ready=%b out_valid=%b, required 0 1", c, in_ready, out_valid);
            end
          end
        end
        out_ready = 1'b1;
      end
    join
    drain(base + 10);
  endtask

  task automatic test_bubbles;
    int base = rx_cnt;
    out_ready = 1'b0;
    issue(ADD, 32'h1234_5678, 32'h1111_1111, 5'd11);
    @(posedge clk); #1;
    issue(SUB_SAT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd12);
    issue(ADD_SAT, 32'h8000_0000, 32'h8000_0000, 5'd13);
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      bad++; $display("FAIL bubble_collapse in_ready=%b out_valid=%b, required 1 1", in_ready, out_valid);
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
    end
    out_ready = 1'b1;
    drain(base + 3);
  endtask

  task automatic test_reset_midstream;
    int cyc;
    int base;
    out_ready = 1'b1;
    issue(ADD, 32'd1, 32'd2, 5'd20);
    issue(SUB, 32'd10, 32'd3, 5'd21);
    issue(ADD_SAT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd22);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || data_res !== '0 || tag_out !== '0) begin
      bad++; $display("FAIL async_reset out_valid=%b res=%h tag=%0d, required 0 0 0", out_valid, data_res, tag_out);
    end
    sb.delete();
    base = rx_cnt;
    @(posedge clk); #3 reset_n = 1'b1;
    @(posedge clk); #1;
    issue(ADD, 32'd100, 32'd23, 5'd25);
    wait_out(cyc);
    total++;
    if (cyc != STAGES || tag_out !== 5'd25 || data_res !== 32'd123) begin
      bad++;
      $display("FAIL post_reset lat=%0d tag=%0d res=%h, required lat=%0d tag=25 res=0000007b", cyc, tag_out, data_res, STAGES);
    end
    @(posedge clk); #1;
    drain(base + 1);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_bubbles;
    test_reset_midstream;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
